ps2_mouse_config_sequencer: RTL and testbench
=============================================

// Module: ps2_mouse_config_sequencer
// PURPOSE
//  Host-side controller for the PS/2 mouse transmitter/receiver pair. Drives the
//  init sequence: reset, self-test, sample rate, resolution, enable streaming.
//  Then assembles 3-byte stream packets into status/dx/dy registers with a
//  per-packet SEND_INTERRUPT. Adds response timeouts, bounded retry and
//  runtime re-init on top of the mouse transceiver datapath.
// PARAMETERS
//  TIMEOUT_CYCLES  5_000_000  max CLK cycles waiting for any init response (100 ms @50 MHz)
//  PKT_TIMEOUT     1_000_000  max CLK cycles between bytes of one stream packet
//  MAX_RETRIES     3          full init attempts before declaring failure
// PORTS
//  CLK              in   1  system clock
//  RESET            in   1  asynchronous, active-low reset
//  SEND_BYTE        out  1  one-cycle request to transmitter
//  BYTE_TO_SEND     out  8  command byte, stable from SEND_BYTE until BYTE_SENT
//  BYTE_SENT        in   1  one-cycle pulse: transmitter finished
//  READ_ENABLE      out  1  enables receiver
//  BYTE_READ        in   8  received byte, valid with BYTE_READY
//  BYTE_ERROR_CODE  in   2  receiver error, 0 = ok, valid with BYTE_READY
//  BYTE_READY       in   1  one-cycle pulse: byte received
//  CFG_SAMPLE_RATE  in   8  sample-rate argument for 0xF3 (sampled at send time)
//  CFG_RESOLUTION   in   2  resolution argument for 0xE8 (zero-extended)
//  REINIT           in   1  one-cycle request: restart init from the beginning
//  MOUSE_STATUS     out  8  last valid packet byte 0
//  MOUSE_DX         out  8  last valid packet byte 1
//  MOUSE_DY         out  8  last valid packet byte 2
//  SEND_INTERRUPT   out  1  one-cycle pulse: new packet registered
//  INIT_DONE        out  1  high while in streaming states
//  INIT_FAIL        out  1  high in FAIL state
//  CURRENT_STATE    out  4  state encoding below, for debug
// BEHAVIOUR
//  - Reset (RESET=0): state RST_TX, all outputs 0, retry count 0, timer 0.
//  - Send states (pulse SEND_BYTE on entry, hold BYTE_TO_SEND, wait BYTE_SENT):
//    0 RST_TX FF | 4 RATE_TX F3 | 6 RARG_TX rate | 8 RES_TX E8 | A RSARG_TX res | C EN_TX F4
//  - Wait states (READ_ENABLE=1, expected byte):
//    1 ACK FA | 2 SELFTEST AA | 3 ID 00 | 5,7,9,B,D ACK FA after each later command.
//    Order: 0-1-2-3-4-5-6-7-8-9-A-B-C-D-E.
//  - A wait state fails on a wrong byte, nonzero BYTE_ERROR_CODE, or timer
//    reaching TIMEOUT_CYCLES. Send states also time out if BYTE_SENT is absent.
//  - Timer is 24-bit and clears on every state change.
//  - On failure: retries+1. If retries < MAX_RETRIES, go to RST_TX; else go to FAIL (F).
//    FAIL holds INIT_FAIL=1 and READ_ENABLE=0 until REINIT.
//  - Stream: E STREAM, READ_ENABLE=1, byte index 0..2.
//    Byte 0 is accepted only if bit3=1; otherwise it is discarded and index stays 0 (resync).
//    Bytes are held in shadow registers. On byte 2, MOUSE_* update from the shadows in
//    the same cycle and SEND_INTERRUPT pulses on the next cycle (1-cycle latency after BYTE_READY).
//    A byte with an error code, or a gap > PKT_TIMEOUT mid-packet, discards the partial
//    packet: index 0, MOUSE_* unchanged, no interrupt. There is no timeout at index 0.
//  - Entering STREAM clears the retry counter and sets INIT_DONE=1.
//  - Priority: RESET > REINIT > BYTE_READY/BYTE_SENT > timeout. A byte arriving on the
//    timeout cycle is processed.
//  - BYTE_READY in send states is ignored.
//  - REINIT in any state: go to RST_TX next cycle, retries=0, INIT_DONE/INIT_FAIL=0.
//    A packet in progress is dropped; MOUSE_* keep their last values.
//  - SEND_BYTE never pulses twice without an intervening BYTE_SENT or state change.
// TESTING
//  1 Nominal init, rate=0x64, res=2: bench acks FA/AA/00/FA... -> BYTE_TO_SEND sequence
//    FF,F3,64,E8,02,F4; INIT_DONE=1; state E.
//  2 Packet 08,05,FB -> MOUSE_STATUS=08, DX=05, DY=FB; one SEND_INTERRUPT 1 cycle after
//    the third BYTE_READY.
//  3 Stream bytes 00,08,01,02 -> first byte dropped (bit3=0); packet 08,01,02 registered
//    with exactly one interrupt.
//  4 Self-test returns 0xFC on every attempt -> 3 attempts (FF sent 3x), then INIT_FAIL=1,
//    state F; REINIT -> FF resent, INIT_FAIL=0.
//  5 No ack after F4 (TIMEOUT_CYCLES=100 in bench) -> retry from RST_TX at cycle 100;
//    second attempt succeeds -> INIT_DONE=1.
//  6 Mid-packet: 08 then gap > PKT_TIMEOUT, then 09,03,04 -> only 09/03/04 registered;
//    REINIT mid-packet -> no interrupt, MOUSE_* unchanged.

Source files
------------

// File: rtl/ps2_mouse_config_sequencer.sv
// -----------------------------------------------------------------------------
// ps2_mouse_config_sequencer
//
// Host-side controller sitting on top of a PS/2 mouse transmitter/receiver
// pair. After reset (or a REINIT request) it walks the mouse through its
// configuration sequence:
//    FF reset -> FA ack, AA self-test pass, 00 device id
//    F3 set sample rate -> FA, <rate> -> FA
//    E8 set resolution  -> FA, <res>  -> FA
//    F4 enable streaming -> FA
// Every step is guarded by a response timeout. A failed step restarts the
// whole sequence until MAX_RETRIES attempts have been used, after which the
// block parks in FAIL. Once streaming, 3-byte movement packets are collected
// and published on MOUSE_* with a one-cycle SEND_INTERRUPT.
//
// Ports
//    CLK, RESET          system clock, asynchronous active-low reset
//    SEND_BYTE           one-cycle transmit request
//    BYTE_TO_SEND[7:0]   command byte, held until the next request
//    BYTE_SENT           transmitter done pulse
//    READ_ENABLE         receiver enable (wait and stream states)
//    BYTE_READ[7:0]      received byte, valid with BYTE_READY
//    BYTE_ERROR_CODE[1:0] receiver error code, 0 = ok
//    BYTE_READY          receiver byte-valid pulse
//    CFG_SAMPLE_RATE[7:0] argument of the F3 command
//    CFG_RESOLUTION[1:0] argument of the E8 command
//    REINIT              restart configuration from the beginning
//    MOUSE_STATUS/DX/DY  last complete packet
//    SEND_INTERRUPT      pulse: new packet published
//    INIT_DONE           high while streaming
//    INIT_FAIL           high in FAIL
//    CURRENT_STATE[3:0]  state encoding for debug
// -----------------------------------------------------------------------------
module ps2_mouse_config_sequencer #(
   parameter int TIMEOUT_CYCLES = 5_000_000,
   parameter int PKT_TIMEOUT    = 1_000_000,
   parameter int MAX_RETRIES    = 3
) (
   input  logic       CLK,
   input  logic       RESET,
   output logic       SEND_BYTE,
   output logic [7:0] BYTE_TO_SEND,
   input  logic       BYTE_SENT,
   output logic       READ_ENABLE,
   input  logic [7:0] BYTE_READ,
   input  logic [1:0] BYTE_ERROR_CODE,
   input  logic       BYTE_READY,
   input  logic [7:0] CFG_SAMPLE_RATE,
   input  logic [1:0] CFG_RESOLUTION,
   input  logic       REINIT,
   output logic [7:0] MOUSE_STATUS,
   output logic [7:0] MOUSE_DX,
   output logic [7:0] MOUSE_DY,
   output logic       SEND_INTERRUPT,
   output logic       INIT_DONE,
   output logic       INIT_FAIL,
   output logic [3:0] CURRENT_STATE
);

   typedef enum logic [3:0] {
      S_RST_TX    = 4'h0,
      S_RST_ACK   = 4'h1,
      S_SELFTEST  = 4'h2,
      S_ID        = 4'h3,
      S_RATE_TX   = 4'h4,
      S_RATE_ACK  = 4'h5,
      S_RARG_TX   = 4'h6,
      S_RARG_ACK  = 4'h7,
      S_RES_TX    = 4'h8,
      S_RES_ACK   = 4'h9,
      S_RSARG_TX  = 4'hA,
      S_RSARG_ACK = 4'hB,
      S_EN_TX     = 4'hC,
      S_EN_ACK    = 4'hD,
      S_STREAM    = 4'hE,
      S_FAIL      = 4'hF
   } state_t;

   // The timers fire when they hold the last value, so a state is left after
   // exactly TIMEOUT_CYCLES (or PKT_TIMEOUT) cycles without progress.
   localparam logic [23:0] TO_LAST     = 24'(TIMEOUT_CYCLES - 1);
   localparam logic [23:0] PKT_LAST    = 24'(PKT_TIMEOUT - 1);
   localparam logic [7:0]  RETRY_LIMIT = 8'(MAX_RETRIES);

   function automatic logic f_is_send(input state_t s);
      return (s == S_RST_TX) || (s == S_RATE_TX) || (s == S_RARG_TX) ||
             (s == S_RES_TX) || (s == S_RSARG_TX) || (s == S_EN_TX);
   endfunction

   function automatic logic f_is_wait(input state_t s);
      return (s == S_RST_ACK) || (s == S_SELFTEST) || (s == S_ID) ||
             (s == S_RATE_ACK) || (s == S_RARG_ACK) || (s == S_RES_ACK) ||
             (s == S_RSARG_ACK) || (s == S_EN_ACK);
   endfunction

   function automatic state_t f_succ(input state_t s);
      case (s)
         S_RST_TX:    return S_RST_ACK;
         S_RST_ACK:   return S_SELFTEST;
         S_SELFTEST:  return S_ID;
         S_ID:        return S_RATE_TX;
         S_RATE_TX:   return S_RATE_ACK;
         S_RATE_ACK:  return S_RARG_TX;
         S_RARG_TX:   return S_RARG_ACK;
         S_RARG_ACK:  return S_RES_TX;
         S_RES_TX:    return S_RES_ACK;
         S_RES_ACK:   return S_RSARG_TX;
         S_RSARG_TX:  return S_RSARG_ACK;
         S_RSARG_ACK: return S_EN_TX;
         S_EN_TX:     return S_EN_ACK;
         S_EN_ACK:    return S_STREAM;
         default:     return s;
      endcase
   endfunction

   function automatic logic [7:0] f_expected(input state_t s);
      case (s)
         S_SELFTEST: return 8'hAA;
         S_ID:       return 8'h00;
         default:    return 8'hFA;
      endcase
   endfunction

   function automatic logic [7:0] f_cmd(input state_t s, input logic [7:0] rate,
                                        input logic [1:0] res);
      case (s)
         S_RST_TX:   return 8'hFF;
         S_RATE_TX:  return 8'hF3;
         S_RARG_TX:  return rate;
         S_RES_TX:   return 8'hE8;
         S_RSARG_TX: return {6'd0, res};
         default:    return 8'hF4;
      endcase
   endfunction

   state_t      r_state;
   logic [23:0] r_timer;
   logic [23:0] r_pkt_timer;
   logic [7:0]  r_retries;
   logic        r_issued;
   logic        r_send_byte;
   logic [7:0]  r_byte_to_send;
   logic        r_read_enable;
   logic        r_init_done;
   logic        r_init_fail;
   logic [1:0]  r_idx;
   logic [7:0]  r_sh_status;
   logic [7:0]  r_sh_dx;
   logic [7:0]  r_mouse_status;
   logic [7:0]  r_mouse_dx;
   logic [7:0]  r_mouse_dy;
   logic        r_send_int;

   state_t      w_next;
   logic        w_fail;
   logic        w_leave;
   logic        w_timeout;

   // Next-state decision. A received/sent event on the timeout cycle wins
   // over the timeout itself.
   always_comb begin
      w_next    = r_state;
      w_fail    = 1'b0;
      w_timeout = (r_timer == TO_LAST);
      if (f_is_send(r_state)) begin
         if (r_issued && BYTE_SENT) begin
            w_next = f_succ(r_state);
         end else if (w_timeout) begin
            w_fail = 1'b1;
         end
      end else if (f_is_wait(r_state)) begin
         if (BYTE_READY) begin
            if ((BYTE_ERROR_CODE != 2'd0) || (BYTE_READ != f_expected(r_state))) begin
               w_fail = 1'b1;
            end else begin
               w_next = f_succ(r_state);
            end
         end else if (w_timeout) begin
            w_fail = 1'b1;
         end
      end
      if (w_fail) begin
         w_next = ((r_retries + 8'd1) < RETRY_LIMIT) ? S_RST_TX : S_FAIL;
      end
      // A retry from RST_TX lands in RST_TX again, so a failure always
      // counts as leaving the state (fresh timer, fresh send request).
      w_leave = w_fail || (w_next != r_state);
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state        <= S_RST_TX;
         r_timer        <= 24'd0;
         r_pkt_timer    <= 24'd0;
         r_retries      <= 8'd0;
         r_issued       <= 1'b0;
         r_send_byte    <= 1'b0;
         r_byte_to_send <= 8'd0;
         r_read_enable  <= 1'b0;
         r_init_done    <= 1'b0;
         r_init_fail    <= 1'b0;
         r_idx          <= 2'd0;
         r_sh_status    <= 8'd0;
         r_sh_dx        <= 8'd0;
         r_mouse_status <= 8'd0;
         r_mouse_dx     <= 8'd0;
         r_mouse_dy     <= 8'd0;
         r_send_int     <= 1'b0;
      end else begin
         r_send_byte <= 1'b0;
         r_send_int  <= 1'b0;
         if (REINIT) begin
            // Partial packet is dropped; published MOUSE_* values are kept.
            r_state       <= S_RST_TX;
            r_retries     <= 8'd0;
            r_timer       <= 24'd0;
            r_pkt_timer   <= 24'd0;
            r_issued      <= 1'b0;
            r_read_enable <= 1'b0;
            r_init_done   <= 1'b0;
            r_init_fail   <= 1'b0;
            r_idx         <= 2'd0;
         end else begin
            r_state       <= w_next;
            r_read_enable <= f_is_wait(w_next) || (w_next == S_STREAM);
            r_init_done   <= (w_next == S_STREAM);
            r_init_fail   <= (w_next == S_FAIL);

            if (w_leave) begin
               r_timer  <= 24'd0;
               r_issued <= 1'b0;
            end else begin
               if (f_is_send(r_state) || f_is_wait(r_state)) begin
                  r_timer <= r_timer + 24'd1;
               end
               // One request per visit to a send state; the argument bytes
               // are sampled here, at request time.
               if (f_is_send(r_state) && !r_issued) begin
                  r_send_byte    <= 1'b1;
                  r_byte_to_send <= f_cmd(r_state, CFG_SAMPLE_RATE, CFG_RESOLUTION);
                  r_issued       <= 1'b1;
               end
            end

            if (w_fail) begin
               r_retries <= r_retries + 8'd1;
            end else if ((w_next == S_STREAM) && (r_state != S_STREAM)) begin
               r_retries <= 8'd0;
            end

            if (r_state == S_STREAM) begin
               if (BYTE_READY) begin
                  r_pkt_timer <= 24'd0;
                  if (BYTE_ERROR_CODE != 2'd0) begin
                     r_idx <= 2'd0;
                  end else begin
                     case (r_idx)
                        2'd0: begin
                           // Bit 3 is always set in a status byte; anything
                           // else is a misaligned byte and is skipped.
                           if (BYTE_READ[3]) begin
                              r_sh_status <= BYTE_READ;
                              r_idx       <= 2'd1;
                           end
                        end
                        2'd1: begin
                           r_sh_dx <= BYTE_READ;
                           r_idx   <= 2'd2;
                        end
                        default: begin
                           r_mouse_status <= r_sh_status;
                           r_mouse_dx     <= r_sh_dx;
                           r_mouse_dy     <= BYTE_READ;
                           r_send_int     <= 1'b1;
                           r_idx          <= 2'd0;
                        end
                     endcase
                  end
               end else if (r_idx != 2'd0) begin
                  if (r_pkt_timer == PKT_LAST) begin
                     r_idx       <= 2'd0;
                     r_pkt_timer <= 24'd0;
                  end else begin
                     r_pkt_timer <= r_pkt_timer + 24'd1;
                  end
               end
            end
         end
      end
   end

   assign SEND_BYTE      = r_send_byte;
   assign BYTE_TO_SEND   = r_byte_to_send;
   assign READ_ENABLE    = r_read_enable;
   assign MOUSE_STATUS   = r_mouse_status;
   assign MOUSE_DX       = r_mouse_dx;
   assign MOUSE_DY       = r_mouse_dy;
   assign SEND_INTERRUPT = r_send_int;
   assign INIT_DONE      = r_init_done;
   assign INIT_FAIL      = r_init_fail;
   assign CURRENT_STATE  = r_state;

endmodule

// File: tb/tb_ps2_mouse_config_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for ps2_mouse_config_sequencer. The bench plays the role of the
// PS/2 transceiver: it acknowledges transmit requests, feeds response and
// stream bytes, and compares the sequencer outputs against hand-computed
// values. Inputs change on the falling edge; outputs are read there too.
// -----------------------------------------------------------------------------
module tb_ps2_mouse_config_sequencer;

   logic       CLK;
   logic       RESET;
   logic       SEND_BYTE;
   logic [7:0] BYTE_TO_SEND;
   logic       BYTE_SENT;
   logic       READ_ENABLE;
   logic [7:0] BYTE_READ;
   logic [1:0] BYTE_ERROR_CODE;
   logic       BYTE_READY;
   logic [7:0] CFG_SAMPLE_RATE;
   logic [1:0] CFG_RESOLUTION;
   logic       REINIT;
   logic [7:0] MOUSE_STATUS;
   logic [7:0] MOUSE_DX;
   logic [7:0] MOUSE_DY;
   logic       SEND_INTERRUPT;
   logic       INIT_DONE;
   logic       INIT_FAIL;
   logic [3:0] CURRENT_STATE;

   int checks   = 0;
   int failures = 0;
   int irq_count = 0;

   ps2_mouse_config_sequencer #(
      .TIMEOUT_CYCLES(100),
      .PKT_TIMEOUT   (50),
      .MAX_RETRIES   (3)
   ) dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .SEND_BYTE      (SEND_BYTE),
      .BYTE_TO_SEND   (BYTE_TO_SEND),
      .BYTE_SENT      (BYTE_SENT),
      .READ_ENABLE    (READ_ENABLE),
      .BYTE_READ      (BYTE_READ),
      .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
      .BYTE_READY     (BYTE_READY),
      .CFG_SAMPLE_RATE(CFG_SAMPLE_RATE),
      .CFG_RESOLUTION (CFG_RESOLUTION),
      .REINIT         (REINIT),
      .MOUSE_STATUS   (MOUSE_STATUS),
      .MOUSE_DX       (MOUSE_DX),
      .MOUSE_DY       (MOUSE_DY),
      .SEND_INTERRUPT (SEND_INTERRUPT),
      .INIT_DONE      (INIT_DONE),
      .INIT_FAIL      (INIT_FAIL),
      .CURRENT_STATE  (CURRENT_STATE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Interrupt pulses counted on the rising edge (pre-update value).
   always @(posedge CLK) begin
      if (SEND_INTERRUPT === 1'b1) irq_count <= irq_count + 1;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers (no checking inside) ----------------
   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic pulse_sent();
      BYTE_SENT = 1'b1;
      tick();
      BYTE_SENT = 1'b0;
   endtask

   task automatic pulse_ready(input logic [7:0] b, input logic [1:0] e);
      BYTE_READ       = b;
      BYTE_ERROR_CODE = e;
      BYTE_READY      = 1'b1;
      tick();
      BYTE_READY      = 1'b0;
      BYTE_ERROR_CODE = 2'd0;
   endtask

   task automatic pulse_reinit();
      REINIT = 1'b1;
      tick();
      REINIT = 1'b0;
   endtask

   task automatic wait_send(input int limit, output logic [7:0] b, output bit ok);
      ok = 1'b0;
      b  = 8'h00;
      for (int i = 0; i < limit; i++) begin
         tick();
         if (SEND_BYTE === 1'b1) begin
            b  = BYTE_TO_SEND;
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Full configuration handshake; returns the number of wrong or missing
   // command bytes. ff_seen: the FF request was already observed.
   task automatic drive_init(input bit ff_seen, input bit drop_last_ack, output int bad);
      logic [7:0] cmds[6];
      logic [7:0] b;
      bit         ok;
      cmds[0] = 8'hFF; cmds[1] = 8'hF3; cmds[2] = CFG_SAMPLE_RATE;
      cmds[3] = 8'hE8; cmds[4] = {6'd0, CFG_RESOLUTION}; cmds[5] = 8'hF4;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         if (!(i == 0 && ff_seen)) begin
            wait_send(20, b, ok);
            if (!ok || b !== cmds[i]) bad++;
         end
         pulse_sent();
         if (i == 0) begin
            pulse_ready(8'hFA, 2'd0);
            pulse_ready(8'hAA, 2'd0);
            pulse_ready(8'h00, 2'd0);
         end else if (!(i == 5 && drop_last_ack)) begin
            pulse_ready(8'hFA, 2'd0);
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      RESET = 1'b0;
      repeat (3) tick();
      checks++;
      if (CURRENT_STATE !== 4'h0) begin failures++; $display("FAIL reset_state got=%h exp=0", CURRENT_STATE); end
      checks++;
      if ({SEND_BYTE, READ_ENABLE, SEND_INTERRUPT, INIT_DONE, INIT_FAIL} !== 5'b0) begin
         failures++; $display("FAIL reset_ctrl got=%b exp=00000", {SEND_BYTE, READ_ENABLE, SEND_INTERRUPT, INIT_DONE, INIT_FAIL});
      end
      checks++;
      if (BYTE_TO_SEND !== 8'h00) begin failures++; $display("FAIL reset_byte got=%h exp=00", BYTE_TO_SEND); end
      checks++;
      if ({MOUSE_STATUS, MOUSE_DX, MOUSE_DY} !== 24'h0) begin
         failures++; $display("FAIL reset_mouse got=%h exp=000000", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY});
      end
      RESET = 1'b1;
   endtask

   task automatic test_nominal_init();
      logic [7:0] exp_cmd[6];
      logic [7:0] b;
      bit         ok;
      exp_cmd[0] = 8'hFF; exp_cmd[1] = 8'hF3; exp_cmd[2] = 8'h64;
      exp_cmd[3] = 8'hE8; exp_cmd[4] = 8'h02; exp_cmd[5] = 8'hF4;
      for (int i = 0; i < 6; i++) begin
         wait_send(20, b, ok);
         checks++;
         if (!ok || b !== exp_cmd[i]) begin
            failures++; $display("FAIL init_cmd%0d got=%h seen=%0d exp=%h", i, b, ok, exp_cmd[i]);
         end
         pulse_sent();
         if (i == 0) begin
            pulse_ready(8'hFA, 2'd0);
            pulse_ready(8'hAA, 2'd0);
            pulse_ready(8'h00, 2'd0);
         end else begin
            pulse_ready(8'hFA, 2'd0);
         end
      end
      checks++;
      if (INIT_DONE !== 1'b1) begin failures++; $display("FAIL init_done got=%b exp=1", INIT_DONE); end
      checks++;
      if (CURRENT_STATE !== 4'hE) begin failures++; $display("FAIL init_state got=%h exp=e", CURRENT_STATE); end
      checks++;
      if (READ_ENABLE !== 1'b1) begin failures++; $display("FAIL init_rden got=%b exp=1", READ_ENABLE); end
      checks++;
      if (INIT_FAIL !== 1'b0) begin failures++; $display("FAIL init_fail got=%b exp=0", INIT_FAIL); end
   endtask

   task automatic test_packet();
      int c0;
      c0 = irq_count;
      pulse_ready(8'h08, 2'd0);
      pulse_ready(8'h05, 2'd0);
      checks++;
      if (SEND_INTERRUPT !== 1'b0) begin failures++; $display("FAIL pkt_irq_early got=%b exp=0", SEND_INTERRUPT); end
      pulse_ready(8'hFB, 2'd0);
      checks++;
      if (SEND_INTERRUPT !== 1'b1) begin failures++; $display("FAIL pkt_irq_latency got=%b exp=1", SEND_INTERRUPT); end
      checks++;
      if ({MOUSE_STATUS, MOUSE_DX, MOUSE_DY} !== 24'h0805FB) begin
         failures++; $display("FAIL pkt_regs got=%h exp=0805fb", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY});
      end
      tick();
      checks++;
      if (SEND_INTERRUPT !== 1'b0) begin failures++; $display("FAIL pkt_irq_width got=%b exp=0", SEND_INTERRUPT); end
      tick();
      checks++;
      if (irq_count - c0 !== 1) begin failures++; $display("FAIL pkt_irq_count got=%0d exp=1", irq_count - c0); end
   endtask

   task automatic test_resync();
      int c0;
      c0 = irq_count;
      pulse_ready(8'h00, 2'd0);
      pulse_ready(8'h08, 2'd0);
      pulse_ready(8'h01, 2'd0);
      pulse_ready(8'h02, 2'd0);
      repeat (2) tick();
      checks++;
      if ({MOUSE_STATUS, MOUSE_DX, MOUSE_DY} !== 24'h080102) begin
         failures++; $display("FAIL resync_regs got=%h exp=080102", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY});
      end
      checks++;
      if (irq_count - c0 !== 1) begin failures++; $display("FAIL resync_irq_count got=%0d exp=1", irq_count - c0); end
   endtask

   task automatic test_error_drop();
      int c0;
      c0 = irq_count;
      pulse_ready(8'h18, 2'd0);
      pulse_ready(8'h05, 2'd1);
      pulse_ready(8'h28, 2'd0);
      pulse_ready(8'h11, 2'd0);
      pulse_ready(8'h22, 2'd0);
      repeat (2) tick();
      checks++;
      if ({MOUSE_STATUS, MOUSE_DX, MOUSE_DY} !== 24'h281122) begin
         failures++; $display("FAIL err_regs got=%h exp=281122", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY});
      end
      checks++;
      if (irq_count - c0 !== 1) begin failures++; $display("FAIL err_irq_count got=%0d exp=1", irq_count - c0); end
   endtask

   task automatic test_pkt_timeout();
      int c0;
      c0 = irq_count;
      pulse_ready(8'h08, 2'd0);
      repeat (60) tick();
      pulse_ready(8'h09, 2'd0);
      pulse_ready(8'h03, 2'd0);
      pulse_ready(8'h04, 2'd0);
      repeat (2) tick();
      checks++;
      if ({MOUSE_STATUS, MOUSE_DX, MOUSE_DY} !== 24'h090304) begin
         failures++; $display("FAIL gap_regs got=%h exp=090304", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY});
      end
      checks++;
      if (irq_count - c0 !== 1) begin failures++; $display("FAIL gap_irq_count got=%0d exp=1", irq_count - c0); end
   endtask

   task automatic test_reinit_midpacket();
      int         c0;
      logic [7:0] b;
      bit         ok;
      c0 = irq_count;
      pulse_ready(8'h0A, 2'd0);
      pulse_ready(8'h07, 2'd0);
      pulse_reinit();
      checks++;
      if (CURRENT_STATE !== 4'h0) begin failures++; $display("FAIL reinit_state got=%h exp=0", CURRENT_STATE); end
      checks++;
      if (INIT_DONE !== 1'b0) begin failures++; $display("FAIL reinit_done got=%b exp=0", INIT_DONE); end
      wait_send(20, b, ok);
      checks++;
      if (!ok || b !== 8'hFF) begin failures++; $display("FAIL reinit_cmd got=%h seen=%0d exp=ff", b, ok); end
      repeat (2) tick();
      checks++;
      if (irq_count - c0 !== 0) begin failures++; $display("FAIL reinit_irq_count got=%0d exp=0", irq_count - c0); end
      checks++;
      if ({MOUSE_STATUS, MOUSE_DX, MOUSE_DY} !== 24'h090304) begin
         failures++; $display("FAIL reinit_regs got=%h exp=090304", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY});
      end
   endtask

   task automatic test_selftest_fail();
      logic [7:0] b;
      bit         ok;
      pulse_reinit();
      for (int a = 0; a < 3; a++) begin
         wait_send(20, b, ok);
         checks++;
         if (!ok || b !== 8'hFF) begin failures++; $display("FAIL stf_attempt%0d got=%h seen=%0d exp=ff", a, b, ok); end
         pulse_sent();
         pulse_ready(8'hFA, 2'd0);
         pulse_ready(8'hFC, 2'd0);
      end
      checks++;
      if (INIT_FAIL !== 1'b1) begin failures++; $display("FAIL stf_fail got=%b exp=1", INIT_FAIL); end
      checks++;
      if (CURRENT_STATE !== 4'hF) begin failures++; $display("FAIL stf_state got=%h exp=f", CURRENT_STATE); end
      checks++;
      if (READ_ENABLE !== 1'b0) begin failures++; $display("FAIL stf_rden got=%b exp=0", READ_ENABLE); end
      wait_send(30, b, ok);
      checks++;
      if (ok !== 1'b0) begin failures++; $display("FAIL stf_extra_send got=%0d exp=0", ok); end
      pulse_reinit();
      checks++;
      if (INIT_FAIL !== 1'b0) begin failures++; $display("FAIL stf_reinit_fail got=%b exp=0", INIT_FAIL); end
      wait_send(20, b, ok);
      checks++;
      if (!ok || b !== 8'hFF) begin failures++; $display("FAIL stf_reinit_cmd got=%h seen=%0d exp=ff", b, ok); end
   endtask

   task automatic test_timeout_retry();
      int bad;
      drive_init(1'b1, 1'b1, bad);
      checks++;
      if (bad !== 0) begin failures++; $display("FAIL to_first_cmds got=%0d exp=0", bad); end
      checks++;
      if (CURRENT_STATE !== 4'hD) begin failures++; $display("FAIL to_enter got=%h exp=d", CURRENT_STATE); end
      repeat (99) tick();
      checks++;
      if (CURRENT_STATE !== 4'hD) begin failures++; $display("FAIL to_cycle99 got=%h exp=d", CURRENT_STATE); end
      tick();
      checks++;
      if (CURRENT_STATE !== 4'h0) begin failures++; $display("FAIL to_cycle100 got=%h exp=0", CURRENT_STATE); end
      drive_init(1'b0, 1'b0, bad);
      checks++;
      if (bad !== 0) begin failures++; $display("FAIL to_retry_cmds got=%0d exp=0", bad); end
      checks++;
      if ({INIT_DONE, INIT_FAIL, CURRENT_STATE} !== 6'b10_1110) begin
         failures++; $display("FAIL to_retry_done got=%b exp=101110", {INIT_DONE, INIT_FAIL, CURRENT_STATE});
      end
   endtask

   initial begin
      RESET           = 1'b0;
      BYTE_SENT       = 1'b0;
      BYTE_READ       = 8'h00;
      BYTE_ERROR_CODE = 2'd0;
      BYTE_READY      = 1'b0;
      CFG_SAMPLE_RATE = 8'h64;
      CFG_RESOLUTION  = 2'd2;
      REINIT          = 1'b0;
      test_reset();
      test_nominal_init();
      test_packet();
      test_resync();
      test_error_drop();
      test_pkt_timeout();
      test_reinit_midpacket();
      test_selftest_fail();
      test_timeout_retry();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
